// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch.
//   state_e  : FSM encoding (IDLE / RUN / PAUSED)
//   digits_t : the four BCD digits, most significant first
//   bcd_step : advance one BCD digit, wrapping at its limit
package bcd_stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10
    } state_e;

    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } digits_t;

    function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic [3:0] max);
        return (d == max) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Synchronises an asynchronous level and turns its rising edge into a
// single-cycle pulse in the clk domain.
//   clk      : sampling clock
//   rst      : asynchronous active-low reset
//   async_in : asynchronous level input
//   tick     : one-cycle pulse per rising edge of async_in
// Every flop resets to 1 so an input that is already high at reset
// release is not mistaken for a fresh rising edge.
module tick_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign tick = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/bcd_stopwatch.sv
// MM:SS BCD stopwatch advanced by a synchronised divided clock.
//   clk, rst          : system clock, asynchronous active-low reset
//   tick_clk          : slow divided clock, sampled as data
//   start/stop/clear  : single-cycle commands (priority clear > stop > start)
//   running           : high while counting
//   sec_ones..min_tens: registered BCD digits
//   rollover          : one-cycle pulse on 59:59 -> 00:00
module bcd_stopwatch
    import bcd_stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_clk,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic       running,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       rollover
);

    logic    tick;
    state_e  state_q, state_d;
    digits_t digits_q, digits_d;
    logic    rollover_q, rollover_d;
    logic    inc, c_so, c_st, c_mo, wrap;

    tick_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .async_in (tick_clk),
        .tick     (tick)
    );

    // Uses the current state, so a tick on the start edge is not counted.
    assign inc  = (state_q == RUN) & tick & ~stop & ~clear;
    assign c_so = inc  & (digits_q.sec_ones == ONES_MAX);
    assign c_st = c_so & (digits_q.sec_tens == TENS_MAX);
    assign c_mo = c_st & (digits_q.min_ones == ONES_MAX);
    assign wrap = c_mo & (digits_q.min_tens == TENS_MAX);

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (stop)  state_d = PAUSED;
                PAUSED:  if (start) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        digits_d   = digits_q;
        rollover_d = 1'b0;
        if (clear) begin
            digits_d = '0;
        end else begin
            if (inc)  digits_d.sec_ones = bcd_step(digits_q.sec_ones, ONES_MAX);
            if (c_so) digits_d.sec_tens = bcd_step(digits_q.sec_tens, TENS_MAX);
            if (c_st) digits_d.min_ones = bcd_step(digits_q.min_ones, ONES_MAX);
            if (c_mo) digits_d.min_tens = bcd_step(digits_q.min_tens, TENS_MAX);
            rollover_d = wrap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            digits_q   <= '0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            rollover_q <= rollover_d;
        end
    end

    assign running  = (state_q == RUN);
    assign sec_ones = digits_q.sec_ones;
    assign sec_tens = digits_q.sec_tens;
    assign min_ones = digits_q.min_ones;
    assign min_tens = digits_q.min_tens;
    assign rollover = rollover_q;

endmodule
